// File: rtl/tdm_slot_mux.sv
// Time-division multiplexer: interleaves NUM_CH parallel streams onto one registered bus,
// one programmable-length slot per active channel, with frame/slot markers for the framer.
module tdm_slot_mux #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    parameter  int CYC_W  = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [CH_W:0]            active_ch,
    input  logic [CYC_W-1:0]         cycles_per_slot,
    input  logic [NUM_CH*DATA_W-1:0] ds_in,
    output logic [DATA_W-1:0]        multiplexed_data,
    output logic [CH_W-1:0]          slot_ch,
    output logic                     data_valid,
    output logic                     slot_start,
    output logic                     frame_start,
    output logic                     cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CH_W:0]    MAX_CH  = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W:0]    ONE_CH  = (CH_W + 1)'(1);
    localparam logic [CYC_W-1:0] ONE_CYC = CYC_W'(1);

    state_t              state_q;
    logic [CH_W-1:0]     ch_ptr_q;
    logic [CYC_W-1:0]    cyc_cnt_q;
    logic [CH_W:0]       n_ch_q;
    logic [CYC_W-1:0]    slot_len_q;
    logic [DATA_W-1:0]   data_q;
    logic [CH_W-1:0]     slot_ch_q;
    logic                valid_q;
    logic                slot_start_q;
    logic                frame_start_q;
    logic                cfg_err_q;

    logic [DATA_W-1:0]   ch_data [NUM_CH];
    logic                last_cyc;
    logic                last_slot;
    logic                frame_boundary;
    logic                cfg_illegal;
    logic [CH_W-1:0]     ch_ptr_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = ds_in[k*DATA_W +: DATA_W];
    end

    // Wrap points are found by comparison; n_ch_q and slot_len_q are never 0 while in RUN.
    assign last_cyc       = (cyc_cnt_q == slot_len_q - ONE_CYC);
    assign last_slot      = ({1'b0, ch_ptr_q} == n_ch_q - ONE_CH);
    assign frame_boundary = (state_q == IDLE) ? enable : (last_cyc && last_slot);
    assign cfg_illegal    = (active_ch == '0) || (active_ch > MAX_CH) || (cycles_per_slot == '0);
    assign ch_ptr_d       = ch_ptr_q + CH_W'(1);

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every
    // register sees the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ch_ptr_q      <= '0;
            cyc_cnt_q     <= '0;
            n_ch_q        <= '0;
            slot_len_q    <= '0;
            data_q        <= '0;
            slot_ch_q     <= '0;
            valid_q       <= 1'b0;
            slot_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            slot_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (frame_boundary) begin
                if (!enable) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end else if (cfg_illegal) begin
                    state_q   <= IDLE;
                    valid_q   <= 1'b0;
                    cfg_err_q <= 1'b1;
                end else begin
                    state_q       <= RUN;
                    n_ch_q        <= active_ch;
                    slot_len_q    <= cycles_per_slot;
                    ch_ptr_q      <= '0;
                    cyc_cnt_q     <= '0;
                    data_q        <= ch_data[0];
                    slot_ch_q     <= '0;
                    valid_q       <= 1'b1;
                    slot_start_q  <= 1'b1;
                    frame_start_q <= 1'b1;
                    cfg_err_q     <= 1'b0;
                end
            end else if (state_q == RUN) begin
                if (!last_cyc) begin
                    cyc_cnt_q <= cyc_cnt_q + ONE_CYC;
                end else begin
                    // Next slot: the new channel is sampled once, here, and held for the slot.
                    ch_ptr_q     <= ch_ptr_d;
                    cyc_cnt_q    <= '0;
                    data_q       <= ch_data[ch_ptr_d];
                    slot_ch_q    <= ch_ptr_d;
                    slot_start_q <= 1'b1;
                end
            end
        end
    end

    assign multiplexed_data = data_q;
    assign slot_ch          = slot_ch_q;
    assign data_valid       = valid_q;
    assign slot_start       = slot_start_q;
    assign frame_start      = frame_start_q;
    assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_tdm_slot_mux.sv
// Bench for tdm_slot_mux: directed scenarios followed by randomized traffic, all checked
// against a frame-position model (cycle index within frame, channel = index / slot length).
module tb_tdm_slot_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CYC_W  = 4;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic [CH_W:0]            active_ch;
    logic [CYC_W-1:0]         cycles_per_slot;
    logic [NUM_CH*DATA_W-1:0] ds_in;
    logic [DATA_W-1:0]        multiplexed_data;
    logic [CH_W-1:0]          slot_ch;
    logic                     data_valid;
    logic                     slot_start;
    logic                     frame_start;
    logic                     cfg_err;

    tdm_slot_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .active_ch        (active_ch),
        .cycles_per_slot  (cycles_per_slot),
        .ds_in            (ds_in),
        .multiplexed_data (multiplexed_data),
        .slot_ch          (slot_ch),
        .data_valid       (data_valid),
        .slot_start       (slot_start),
        .frame_start      (frame_start),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position t counts cycles from frame start.
    bit          m_run = 1'b0;
    int          m_n = 0;
    int          m_len = 0;
    int          m_t = 0;
    int          m_ch = 0;
    logic [7:0]  m_data = '0;
    bit          m_valid = 1'b0;
    bit          m_ss = 1'b0;
    bit          m_fs = 1'b0;
    bit          m_err = 1'b0;

    task automatic model_edge();
        bit boundary;
        bit illegal;
        if (rst) begin
            m_run = 0; m_n = 0; m_len = 0; m_t = 0; m_ch = 0; m_data = '0;
            m_valid = 0; m_ss = 0; m_fs = 0; m_err = 0;
            return;
        end
        boundary = (!m_run && enable) || (m_run && (m_t == m_n * m_len - 1));
        illegal  = (int'(active_ch) == 0) || (int'(active_ch) > NUM_CH) || (int'(cycles_per_slot) == 0);
        m_ss = 0;
        m_fs = 0;
        if (boundary) begin
            if (!enable) begin
                m_run = 0; m_valid = 0;
            end else if (illegal) begin
                m_run = 0; m_valid = 0; m_err = 1;
            end else begin
                m_run = 1; m_n = int'(active_ch); m_len = int'(cycles_per_slot);
                m_t = 0; m_ch = 0; m_data = ds_in[0 +: DATA_W];
                m_valid = 1; m_ss = 1; m_fs = 1; m_err = 0;
            end
        end else if (m_run) begin
            m_t++;
            if (m_t % m_len == 0) begin
                m_ch   = m_t / m_len;
                m_data = ds_in[m_ch*DATA_W +: DATA_W];
                m_ss   = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("data",        32'(multiplexed_data), 32'(m_data));
        check("slot_ch",     32'(slot_ch),          32'(m_ch));
        check("data_valid",  32'(data_valid),       32'(m_valid));
        check("slot_start",  32'(slot_start),       32'(m_ss));
        check("frame_start", 32'(frame_start),      32'(m_fs));
        check("cfg_err",     32'(cfg_err),          32'(m_err));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst             = 1'b1;
        enable          = 1'b1;
        active_ch       = 3'd4;
        cycles_per_slot = 4'd2;
        ds_in           = {8'h44, 8'h33, 8'h22, 8'h11};
        ticks(2);
        check("reset_data",  32'(multiplexed_data), 32'h0);
        check("reset_valid", 32'(data_valid),       32'h0);

        // Reset mid-frame, enable held: channel 0 returns one edge after reset falls.
        rst = 1'b0;
        ticks(5);
        rst = 1'b1;
        tick();
        check("midrst_data",  32'(multiplexed_data), 32'h0);
        check("midrst_valid", 32'(data_valid),       32'h0);
        check("midrst_fs",    32'(frame_start),      32'h0);
        rst = 1'b0;
        tick();
        check("restart_data", 32'(multiplexed_data), 32'h11);
        check("restart_fs",   32'(frame_start),      32'h1);

        // Single channel, 6-cycle slots.
        active_ch = 3'd1; cycles_per_slot = 4'd6;
        ticks(30);

        // Three channels, 2-cycle slots.
        active_ch = 3'd3; cycles_per_slot = 4'd2;
        ticks(30);

        // Config change during slot 1 of a 2x3 frame.
        active_ch = 3'd2; cycles_per_slot = 4'd3;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_fs && m_n == 2) break;
        end
        check("s4_sync", 32'(m_n), 32'd2);
        ticks(3);
        check("s4_slot1", 32'(multiplexed_data), 32'h22);
        active_ch = 3'd4; cycles_per_slot = 4'd1;
        ticks(20);

        // Enable drop during slot 0 of a 4x2 frame.
        active_ch = 3'd4; cycles_per_slot = 4'd2;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_fs && m_n == 4 && m_len == 2) break;
        end
        check("s5_sync", 32'(m_len), 32'd2);
        enable = 1'b0;
        ticks(10);
        check("s5_hold_data",  32'(multiplexed_data), 32'h44);
        check("s5_hold_valid", 32'(data_valid),       32'h0);

        // Illegal configurations, then a legal one.
        enable = 1'b1; active_ch = 3'd0;
        tick();
        check("ill0_err",   32'(cfg_err),    32'h1);
        check("ill0_valid", 32'(data_valid), 32'h0);
        active_ch = 3'd5;
        tick();
        check("ill5_err",   32'(cfg_err),    32'h1);
        check("ill5_valid", 32'(data_valid), 32'h0);
        active_ch = 3'd2;
        tick();
        check("fix_fs",  32'(frame_start), 32'h1);
        check("fix_err", 32'(cfg_err),     32'h0);
        ticks(8);

        // Randomized traffic: data changes every cycle, occasional config/enable/reset changes.
        for (int i = 0; i < 2500; i++) begin
            ds_in = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                active_ch       = 3'($urandom_range(0, 5));
                cycles_per_slot = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
